mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, meaning RAM byte-address width (128 KB).
REQ-002 SHALL have parameter TX_DEPTH, default 8, meaning TX FIFO entries (power of 2).
REQ-003 SHALL have parameter FULL_MARGIN, default 2, meaning free entries below which io_buffer_full asserts.
REQ-004 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-006 SHALL have port mem_a, input, 32, CPU address; only bits 17:0 decoded.
REQ-007 SHALL have port mem_dout, input, 8, CPU write data.
REQ-008 SHALL have port mem_wr, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port mem_din, output, 8, read data returned to CPU.
REQ-010 SHALL have port io_buffer_full, output, 1, TX FIFO near-full to CPU.
REQ-011 SHALL have port rx_data, input, 8, UART receive byte.
REQ-012 SHALL have port rx_valid, input, 1, rx_data holds an unread byte.
REQ-013 SHALL have port rx_pop, output, 1, one-cycle pulse consuming rx_data.
REQ-014 SHALL have port tx_data, output, 8, TX FIFO head byte.
REQ-015 SHALL have port tx_valid, output, 1, TX FIFO non-empty.
REQ-016 SHALL have port tx_ready, input, 1, UART accepts tx_data when tx_valid && tx_ready.
REQ-017 SHALL have port program_stop, output, 1, sticky; set by stop write.
REQ-018 SHALL have port tx_overflow, output, 1, sticky; TX byte dropped.

Function
REQ-019 SHALL decode mem_a[17:16]==2'b11 as I/O, all other values as RAM at mem_a[RAM_AW-1:0].
REQ-020 SHALL service one access every cycle; no wait states.
REQ-021 SHALL perform a RAM write in the cycle mem_wr=1 is presented.
REQ-022 SHALL return RAM read data on mem_din exactly one cycle after the read address, registered.
REQ-023 SHALL return the new byte for a read in the cycle after a write to the same address.
REQ-024 SHALL, for an I/O read of 0x30000 with rx_valid=1, pulse rx_pop that cycle and return rx_data on mem_din next cycle.
REQ-025 SHALL, for an I/O read of 0x30000 with rx_valid=0, return 0x00 next cycle without pulsing rx_pop.
REQ-026 SHALL keep a 32-bit cycle counter: 0 after reset, +1 every cycle, wraps 0xFFFFFFFF->0.
REQ-027 SHALL, on a read of 0x30004, snapshot the counter and return byte 0 (LSB) next cycle.
REQ-028 SHALL return snapshot bytes 1..3 for reads of 0x30005..0x30007; the snapshot is unchanged until the next 0x30004 read.
REQ-029 SHALL, on write of 0x30000 with nonzero data, push the byte into the TX FIFO; 0x00 writes are ignored.
REQ-030 SHALL, on write of 0x30004, push 0x00 into the TX FIFO and set program_stop.
REQ-031 SHALL accept a push when count<TX_DEPTH, or when count==TX_DEPTH and a pop occurs the same cycle.
REQ-032 SHALL otherwise drop the push, set tx_overflow, and leave FIFO contents unchanged.
REQ-033 SHALL pop when tx_valid && tx_ready; simultaneous push and pop leave count unchanged.
REQ-034 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-035 SHALL drive io_buffer_full = (count >= TX_DEPTH-FULL_MARGIN), combinational from count.
REQ-036 SHALL return 0x00 for reads of other I/O addresses and ignore writes to them.
REQ-037 SHALL wrap FIFO pointers modulo TX_DEPTH.

Reset
REQ-038 SHALL, while rst_in=1 at a clock edge, clear mem_din, rx_pop, tx_valid, FIFO count and pointers, counter, snapshot, program_stop and tx_overflow to 0.
REQ-039 SHALL leave RAM contents unchanged by reset.
REQ-040 SHALL discard an access in flight when reset is asserted: mem_din=0, no push, no rx_pop.

Verification
REQ-041 SHALL cover: write 0xA5 to 0x00100, read 0x00100 next cycle -> mem_din=0xA5 one cycle after read.
REQ-042 SHALL cover: rx_valid=1, rx_data=0x41, read 0x30000 -> rx_pop pulse same cycle, mem_din=0x41 next cycle; rx_valid=0 -> 0x00, no pulse.
REQ-043 SHALL cover: 10 cycles after reset read 0x30004..0x30007 on consecutive cycles -> bytes of one snapshot (0x0A,0,0,0 ±pipeline offset fixed by REQ-027).
REQ-044 SHALL cover: tx_ready=0, write 0x31 x6 -> io_buffer_full=1 after 6th push; 3 more writes -> 2 accepted, 9th dropped, tx_overflow=1.
REQ-045 SHALL cover: write 0x00 to 0x30000 -> no push; write 0x30004 -> 0x00 queued, program_stop=1 until reset.
REQ-046 SHALL cover: FIFO full, tx_ready=1, write 0x42 same cycle -> accepted, count stays 8, no overflow.

Source files
------------

// File: rtl/mem_io_responder.sv
// CPU-side memory/IO responder: byte RAM, UART RX port, TX FIFO,
// free-running cycle counter with snapshot, and a program-stop latch.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = $clog2(TX_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(TX_DEPTH);
    localparam logic [CW-1:0] C_THR   = CW'(TX_DEPTH - FULL_MARGIN);
    localparam logic [PW-1:0] C_LAST  = PW'(TX_DEPTH - 1);

    localparam logic [17:0] A_RX   = 18'h30000;
    localparam logic [17:0] A_CNT0 = 18'h30004;
    localparam logic [17:0] A_CNT1 = 18'h30005;
    localparam logic [17:0] A_CNT2 = 18'h30006;
    localparam logic [17:0] A_CNT3 = 18'h30007;

    logic [17:0]       w_addr;
    logic              w_is_io;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_rd;
    logic              w_wr;
    logic [7:0]        w_io_rd;
    logic              w_push_req;
    logic [7:0]        w_push_data;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    logic [7:0]        r_ram [0:(1<<RAM_AW)-1];
    logic [7:0]        r_ram_rd;
    logic              r_sel_ram;
    logic [7:0]        r_io_rd;
    logic [31:0]       r_cnt;
    logic [31:0]       r_snap;
    logic              r_stop;
    logic              r_ovf;

    logic [7:0]        r_fifo [0:TX_DEPTH-1];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_count;

    assign w_addr    = mem_a[17:0];
    assign w_is_io   = (w_addr[17:16] == 2'b11);
    assign w_ram_idx = mem_a[RAM_AW-1:0];
    assign w_rd      = !rst_in && !mem_wr;
    assign w_wr      = !rst_in && mem_wr;
    assign w_unused  = ^mem_a[31:18];

    // RAM kept reset-free so it maps onto block memory
    always_ff @(posedge clk_in) begin
        if (w_wr && !w_is_io)
            r_ram[w_ram_idx] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (w_rd && !w_is_io)
            r_ram_rd <= r_ram[w_ram_idx];
    end

    always_comb begin
        w_io_rd = 8'h00;
        case (w_addr)
            A_RX:    w_io_rd = rx_valid ? rx_data : 8'h00;
            A_CNT0:  w_io_rd = r_cnt[7:0];
            A_CNT1:  w_io_rd = r_snap[15:8];
            A_CNT2:  w_io_rd = r_snap[23:16];
            A_CNT3:  w_io_rd = r_snap[31:24];
            default: w_io_rd = 8'h00;
        endcase
    end

    assign rx_pop = w_rd && w_is_io && (w_addr == A_RX) && rx_valid;

    assign w_push_req = w_wr && w_is_io &&
                        (((w_addr == A_RX) && (mem_dout != 8'h00)) ||
                         (w_addr == A_CNT0));
    assign w_push_data = (w_addr == A_CNT0) ? 8'h00 : mem_dout;

    assign tx_valid = (r_count != '0);
    assign w_pop    = tx_valid && tx_ready;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign w_push   = w_push_req && ((r_count != C_DEPTH) || w_pop);

    assign tx_data        = r_fifo[r_rp];
    assign io_buffer_full = (r_count >= C_THR);

    always_ff @(posedge clk_in) begin
        if (w_push)
            r_fifo[r_wp] <= w_push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wp <= (r_wp == C_LAST) ? '0 : r_wp + 1'b1;
            if (w_pop)
                r_rp <= (r_rp == C_LAST) ? '0 : r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_ram <= 1'b0;
            r_io_rd   <= 8'h00;
            r_cnt     <= 32'h0;
            r_snap    <= 32'h0;
            r_stop    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 32'h1;
            r_sel_ram <= w_rd && !w_is_io;
            r_io_rd   <= (w_rd && w_is_io) ? w_io_rd : 8'h00;
            if (w_rd && w_is_io && (w_addr == A_CNT0))
                r_snap <= r_cnt;
            if (w_wr && w_is_io && (w_addr == A_CNT0))
                r_stop <= 1'b1;
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
        end
    end

    assign mem_din      = r_sel_ram ? r_ram_rd : r_io_rd;
    assign program_stop = r_stop;
    assign tx_overflow  = r_ovf;

endmodule
